// File: rtl/datapath_if.sv
// Strobe, memory-data and observation bundle between a sequencer (master) and the datapath slice (slave).
interface datapath_if;
    logic [31:0] Mdatain;
    logic        Read;
    logic        MDRin, R1in, R6in, R7in, IRin, Yin, HIin;
    logic        AND;
    logic        PCout, MDRout, Zlowout, ZHighout, R6out, R7out;
    logic [31:0] BusMuxOut;
    logic [31:0] R1q, R6q, R7q, PCq, IRq, MDRq, Yq, ZLowq, ZHighq, HIq;

    modport master (
        output Mdatain, Read,
        output MDRin, R1in, R6in, R7in, IRin, Yin, HIin, AND,
        output PCout, MDRout, Zlowout, ZHighout, R6out, R7out,
        input  BusMuxOut,
        input  R1q, R6q, R7q, PCq, IRq, MDRq, Yq, ZLowq, ZHighq, HIq
    );

    modport slave (
        input  Mdatain, Read,
        input  MDRin, R1in, R6in, R7in, IRin, Yin, HIin, AND,
        input  PCout, MDRout, Zlowout, ZHighout, R6out, R7out,
        output BusMuxOut,
        output R1q, R6q, R7q, PCq, IRq, MDRq, Yq, ZLowq, ZHighq, HIq
    );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit datapath slice: shared bus, MDR with memory mux, general registers and an AND ALU into a 64-bit Z.
module datapath (
    input  logic       clock,
    input  logic       clear,
    datapath_if.slave  bus_if
);
    logic [31:0] bus_d;
    logic [31:0] mdr_d;
    logic [31:0] z_low_d;

    logic [31:0] r1_q, r6_q, r7_q, pc_q, ir_q, mdr_q, y_q, z_low_q, z_high_q, hi_q;

    // Fixed source priority; an idle bus reads as zero rather than floating.
    always_comb begin
        bus_d = 32'h0;
        if (bus_if.MDRout)
            bus_d = mdr_q;
        else if (bus_if.Zlowout)
            bus_d = z_low_q;
        else if (bus_if.ZHighout)
            bus_d = z_high_q;
        else if (bus_if.PCout)
            bus_d = pc_q;
        else if (bus_if.R6out)
            bus_d = r6_q;
        else if (bus_if.R7out)
            bus_d = r7_q;
    end

    assign mdr_d   = bus_if.Read ? bus_if.Mdatain : bus_d;
    assign z_low_d = y_q & bus_d;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r1_q     <= 32'h0;
            r6_q     <= 32'h0;
            r7_q     <= 32'h0;
            pc_q     <= 32'h0;
            ir_q     <= 32'h0;
            mdr_q    <= 32'h0;
            y_q      <= 32'h0;
            z_low_q  <= 32'h0;
            z_high_q <= 32'h0;
            hi_q     <= 32'h0;
        end else begin
            if (bus_if.MDRin) mdr_q <= mdr_d;
            if (bus_if.R1in)  r1_q  <= bus_d;
            if (bus_if.R6in)  r6_q  <= bus_d;
            if (bus_if.R7in)  r7_q  <= bus_d;
            if (bus_if.IRin)  ir_q  <= bus_d;
            if (bus_if.Yin)   y_q   <= bus_d;
            if (bus_if.HIin)  hi_q  <= bus_d;
            // The upper half of the ALU result is always zero for AND.
            if (bus_if.AND) begin
                z_low_q  <= z_low_d;
                z_high_q <= 32'h0;
            end
        end
    end

    assign bus_if.BusMuxOut = bus_d;
    assign bus_if.R1q       = r1_q;
    assign bus_if.R6q       = r6_q;
    assign bus_if.R7q       = r7_q;
    assign bus_if.PCq       = pc_q;
    assign bus_if.IRq       = ir_q;
    assign bus_if.MDRq      = mdr_q;
    assign bus_if.Yq        = y_q;
    assign bus_if.ZLowq     = z_low_q;
    assign bus_if.ZHighq    = z_high_q;
    assign bus_if.HIq       = hi_q;
endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath slice: register transfers, AND into Z, bus priority, async clear and hold.
module tb_datapath;
    logic clock;
    logic clear;
    datapath_if dif ();

    datapath dut (
        .clock  (clock),
        .clear  (clear),
        .bus_if (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] e_r1, e_r6, e_r7, e_pc, e_ir, e_mdr, e_y, e_zl, e_zh, e_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".R1"},    dif.R1q,    e_r1);
        chk({tag, ".R6"},    dif.R6q,    e_r6);
        chk({tag, ".R7"},    dif.R7q,    e_r7);
        chk({tag, ".PC"},    dif.PCq,    e_pc);
        chk({tag, ".IR"},    dif.IRq,    e_ir);
        chk({tag, ".MDR"},   dif.MDRq,   e_mdr);
        chk({tag, ".Y"},     dif.Yq,     e_y);
        chk({tag, ".ZLow"},  dif.ZLowq,  e_zl);
        chk({tag, ".ZHigh"}, dif.ZHighq, e_zh);
        chk({tag, ".HI"},    dif.HIq,    e_hi);
    endtask

    task automatic zero_exp();
        e_r1 = 0; e_r6 = 0; e_r7 = 0; e_pc = 0; e_ir = 0;
        e_mdr = 0; e_y = 0; e_zl = 0; e_zh = 0; e_hi = 0;
    endtask

    task automatic idle();
        dif.Read = 0; dif.MDRin = 0; dif.R1in = 0; dif.R6in = 0; dif.R7in = 0;
        dif.IRin = 0; dif.Yin = 0; dif.HIin = 0; dif.AND = 0;
        dif.PCout = 0; dif.MDRout = 0; dif.Zlowout = 0; dif.ZHighout = 0;
        dif.R6out = 0; dif.R7out = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_to_mdr(input logic [31:0] data);
        idle();
        dif.Mdatain = data; dif.Read = 1; dif.MDRin = 1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        dif.Mdatain = 32'h0;
        clear = 1'b1;
        zero_exp();
        #1 clear = 1'b0;
        #1;
        chk_all("reset");
        chk("reset.bus", dif.BusMuxOut, 32'h0);

        // Enables during reset are ignored across an edge.
        dif.Mdatain = 32'h99; dif.Read = 1; dif.MDRin = 1; dif.R1in = 1;
        tick();
        chk("reset.noload.MDR", dif.MDRq, 32'h0);
        idle();
        clear = 1'b1;

        // Load R6 = 0x12 via MDR.
        mem_to_mdr(32'h12);
        e_mdr = 32'h12;
        chk("ldR6.MDR", dif.MDRq, e_mdr);
        dif.MDRout = 1; dif.R6in = 1;
        #1 chk("ldR6.bus", dif.BusMuxOut, 32'h12);
        tick(); idle();
        e_r6 = 32'h12;
        chk("ldR6.R6", dif.R6q, e_r6);

        mem_to_mdr(32'h14);
        dif.MDRout = 1; dif.R7in = 1; tick(); idle();
        e_r7 = 32'h14;
        chk("ldR7.R7", dif.R7q, e_r7);

        mem_to_mdr(32'h18);
        dif.MDRout = 1; dif.R1in = 1; tick(); idle();
        e_r1 = 32'h18;
        chk("ldR1.R1", dif.R1q, e_r1);

        mem_to_mdr(32'h5);
        dif.MDRout = 1; dif.IRin = 1; tick(); idle();
        e_ir = 32'h5; e_mdr = 32'h5;
        chk_all("ldIR");

        // HI gets a nonzero value first so the ZHigh transfer is visible.
        dif.MDRout = 1; dif.HIin = 1; tick(); idle();
        e_hi = 32'h5;
        chk("ldHI.HI", dif.HIq, e_hi);

        dif.R6out = 1; dif.Yin = 1; tick(); idle();
        e_y = 32'h12;
        chk("and.Y", dif.Yq, e_y);
        dif.R7out = 1; dif.AND = 1;
        #1 chk("and.bus", dif.BusMuxOut, 32'h14);
        tick(); idle();
        e_zl = 32'h10; e_zh = 32'h0;
        chk("and.ZLow", dif.ZLowq, e_zl);
        chk("and.ZHigh", dif.ZHighq, e_zh);
        dif.Zlowout = 1; dif.R1in = 1; tick(); idle();
        e_r1 = 32'h10;
        chk("zlow.R1", dif.R1q, e_r1);
        dif.ZHighout = 1; dif.HIin = 1; tick(); idle();
        e_hi = 32'h0;
        chk("zhigh.HI", dif.HIq, e_hi);

        // Bus priority.
        mem_to_mdr(32'hAAAA);
        e_mdr = 32'hAAAA;
        dif.MDRout = 1; dif.R6out = 1; dif.R1in = 1;
        #1 chk("prio.mdr_r6.bus", dif.BusMuxOut, 32'hAAAA);
        tick(); idle();
        e_r1 = 32'hAAAA;
        chk("prio.R1", dif.R1q, e_r1);
        dif.Zlowout = 1; dif.ZHighout = 1; dif.R6out = 1;
        #1 chk("prio.zl_zh", dif.BusMuxOut, 32'h10);
        idle(); dif.ZHighout = 1; dif.PCout = 1; dif.R6out = 1;
        #1 chk("prio.zh_pc", dif.BusMuxOut, 32'h0);
        idle(); dif.PCout = 1; dif.R6out = 1;
        #1 chk("prio.pc_r6", dif.BusMuxOut, 32'h0);
        idle(); dif.R6out = 1; dif.R7out = 1;
        #1 chk("prio.r6_r7", dif.BusMuxOut, 32'h12);
        idle(); dif.R7out = 1;
        #1 chk("prio.r7", dif.BusMuxOut, 32'h14);
        idle();
        #1 chk("prio.none", dif.BusMuxOut, 32'h0);

        // Self-load of R6 while R7 captures the same bus value.
        dif.R6out = 1; dif.R6in = 1; dif.R7in = 1; tick(); idle();
        e_r7 = 32'h12;
        chk_all("selfload");

        // Read without MDRin does nothing.
        dif.Mdatain = 32'hDEAD; dif.Read = 1; tick(); idle();
        chk("readonly.MDR", dif.MDRq, e_mdr);

        // MDR loading from the bus.
        dif.R7out = 1; dif.MDRin = 1; tick(); idle();
        e_mdr = 32'h12;
        chk("mdrbus.MDR", dif.MDRq, e_mdr);

        // Hold with toggling memory data.
        for (int i = 0; i < 5; i++) begin
            dif.Mdatain = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            tick();
        end
        chk_all("hold");

        // Asynchronous clear between edges.
        #2 clear = 1'b0;
        #1;
        zero_exp();
        chk_all("midclr");
        dif.Mdatain = 32'h77; dif.Read = 1; dif.MDRin = 1; dif.R6in = 1; dif.MDRout = 1;
        #1 chk("midclr.bus", dif.BusMuxOut, 32'h0);
        tick();
        chk_all("midclr.edge");
        #2 clear = 1'b1;
        idle();
        dif.Mdatain = 32'h77; dif.Read = 1; dif.MDRin = 1;
        tick(); idle();
        e_mdr = 32'h77;
        chk_all("release");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
